// File: rtl/spi_apb_pkg.sv
// Shared register map and bit positions for the APB front end of the SPI controller.
package spi_apb_pkg;

  localparam int REG_CTRL   = 0;
  localparam int REG_CLKDIV = 1;
  localparam int REG_STATUS = 2;
  localparam int REG_TXDATA = 3;
  localparam int REG_RXDATA = 4;
  localparam int REG_COUNT  = 5;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_CPOL    = 1;
  localparam int CTRL_CPHA    = 2;
  localparam int CTRL_LSBF    = 3;
  localparam int CTRL_TXE_IE  = 4;
  localparam int CTRL_RXNE_IE = 5;
  localparam int CTRL_W       = 6;

  localparam int ST_TXF = 0;
  localparam int ST_TXE = 1;
  localparam int ST_RXF = 2;
  localparam int ST_RXE = 3;
  localparam int ST_OVF = 4;

  // Field order matches the STATUS bit layout, MSB first.
  typedef struct packed {
    logic ovf;
    logic rxe;
    logic rxf;
    logic txe;
    logic txf;
  } status_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// First-word fall-through synchronous FIFO of arbitrary depth (>= 2) with occupancy count.
module spi_sync_fifo #(
  parameter int DWIDTH     = 8,
  parameter int FIFO_DEPTH = 5
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               push,
  input  logic                               pop,
  input  logic [DWIDTH-1:0]                  wdata,
  output logic [DWIDTH-1:0]                  rdata,
  output logic                               full,
  output logic                               empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [DWIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_reg;
  logic [PW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic [CW-1:0]     count_next;
  logic              do_push;
  logic              do_pop;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(FIFO_DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wdata;
  end

  assign rdata = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/apb_spi_regfile.sv
// APB3 register file for the SPI controller: config registers, status, counts,
// TX/RX data FIFOs, sticky RX overflow and a registered level interrupt.
module apb_spi_regfile
  import spi_apb_pkg::*;
#(
  parameter int AWIDTH     = 4,
  parameter int DWIDTH     = 8,
  parameter int FIFO_DEPTH = 5,
  parameter int N          = $clog2(FIFO_DEPTH + 1),
  parameter int REGN       = 6,
  parameter int CLK_DIV    = 2
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [AWIDTH-1:0] PADDR,
  input  logic [DWIDTH-1:0] PWDATA,
  output logic [DWIDTH-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              cfg_en,
  output logic              cfg_cpol,
  output logic              cfg_cpha,
  output logic              cfg_lsbf,
  output logic [DWIDTH-1:0] cfg_clkdiv,
  output logic [DWIDTH-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DWIDTH-1:0] rx_data,
  input  logic              rx_valid,
  output logic              irq
);

  localparam logic [AWIDTH-1:0] A_CTRL   = AWIDTH'(REG_CTRL);
  localparam logic [AWIDTH-1:0] A_CLKDIV = AWIDTH'(REG_CLKDIV);
  localparam logic [AWIDTH-1:0] A_STATUS = AWIDTH'(REG_STATUS);
  localparam logic [AWIDTH-1:0] A_TXDATA = AWIDTH'(REG_TXDATA);
  localparam logic [AWIDTH-1:0] A_RXDATA = AWIDTH'(REG_RXDATA);
  localparam logic [AWIDTH-1:0] A_COUNT  = AWIDTH'(REG_COUNT);
  localparam logic [31:0]       REGN_U   = 32'(REGN);

  logic [CTRL_W-1:0] ctrl_reg;
  logic [DWIDTH-1:0] clkdiv_reg;
  logic              ovf_reg;
  logic              ovf_next;
  logic              irq_reg;

  logic              access;
  logic              bad_idx;
  logic              err;
  logic              wr_ok;
  logic              rd_ok;

  logic              tx_full;
  logic              tx_empty;
  logic [N-1:0]      tx_cnt;
  logic              tx_push;
  logic              tx_pop;

  logic              rx_full;
  logic              rx_empty;
  logic [N-1:0]      rx_cnt;
  logic [DWIDTH-1:0] rx_head;
  logic              rx_push;
  logic              rx_pop;
  logic              ovf_set;

  status_t           status;

  assign access  = PSEL & PENABLE;
  assign bad_idx = ({{(32 - AWIDTH){1'b0}}, PADDR} >= REGN_U);

  // Fullness/emptiness are judged on start-of-cycle state, so a same-cycle engine pop
  // does not rescue a TXDATA write into a full FIFO.
  assign err = access & (bad_idx
                        | ( PWRITE & (PADDR == A_TXDATA) & tx_full)
                        | (~PWRITE & (PADDR == A_RXDATA) & rx_empty));

  assign wr_ok   = access &  PWRITE & ~err;
  assign rd_ok   = access & ~PWRITE & ~err;
  assign PSLVERR = err;
  assign PREADY  = 1'b1;

  assign tx_push = wr_ok & (PADDR == A_TXDATA);
  assign tx_pop  = tx_ready & ~tx_empty;
  assign rx_pop  = rd_ok & (PADDR == A_RXDATA);
  assign rx_push = rx_valid & (~rx_full | rx_pop);
  assign ovf_set = rx_valid & rx_full & ~rx_pop;

  spi_sync_fifo #(
    .DWIDTH     (DWIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (PWDATA),
    .rdata (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_cnt)
  );

  spi_sync_fifo #(
    .DWIDTH     (DWIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .push  (rx_push),
    .pop   (rx_pop),
    .wdata (rx_data),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_cnt)
  );

  assign tx_valid = ~tx_empty;

  always_comb begin
    status.ovf = ovf_reg;
    status.rxe = rx_empty;
    status.rxf = rx_full;
    status.txe = tx_empty;
    status.txf = tx_full;
  end

  always_comb begin
    PRDATA = '0;
    if (rd_ok) begin
      case (PADDR)
        A_CTRL:   PRDATA = DWIDTH'(ctrl_reg);
        A_CLKDIV: PRDATA = clkdiv_reg;
        A_STATUS: PRDATA = DWIDTH'(status);
        A_RXDATA: PRDATA = rx_head;
        A_COUNT:  PRDATA = DWIDTH'({rx_cnt, tx_cnt});
        default:  PRDATA = '0;
      endcase
    end
  end

  // A dropped frame in the same cycle as the W1C write keeps the flag set.
  always_comb begin
    ovf_next = ovf_reg;
    if (ovf_set)
      ovf_next = 1'b1;
    else if (wr_ok && (PADDR == A_STATUS) && PWDATA[ST_OVF])
      ovf_next = 1'b0;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ctrl_reg   <= '0;
      clkdiv_reg <= DWIDTH'(CLK_DIV);
      ovf_reg    <= 1'b0;
      irq_reg    <= 1'b0;
    end else begin
      if (wr_ok && (PADDR == A_CTRL))   ctrl_reg   <= PWDATA[CTRL_W-1:0];
      if (wr_ok && (PADDR == A_CLKDIV)) clkdiv_reg <= PWDATA;
      ovf_reg <= ovf_next;
      irq_reg <= (ctrl_reg[CTRL_TXE_IE]  &  tx_empty)
               | (ctrl_reg[CTRL_RXNE_IE] & ~rx_empty)
               | ovf_reg;
    end
  end

  assign cfg_en     = ctrl_reg[CTRL_EN];
  assign cfg_cpol   = ctrl_reg[CTRL_CPOL];
  assign cfg_cpha   = ctrl_reg[CTRL_CPHA];
  assign cfg_lsbf   = ctrl_reg[CTRL_LSBF];
  assign cfg_clkdiv = clkdiv_reg;
  assign irq        = irq_reg;

endmodule

// File: tb/tb_apb_spi_regfile.sv
// Self-checking bench for apb_spi_regfile: queue-based reference model checked every cycle,
// plus directed APB/engine sequences with literal expectations.
module tb_apb_spi_regfile;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic          pready, pslverr;
  logic          cfg_en, cfg_cpol, cfg_cpha, cfg_lsbf;
  logic [DW-1:0] cfg_clkdiv, tx_data, rx_data;
  logic          tx_valid, tx_ready, rx_valid, irq;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  apb_spi_regfile dut (
    .PCLK       (clk),
    .PRESETn    (rst_n),
    .PSEL       (psel),
    .PENABLE    (penable),
    .PWRITE     (pwrite),
    .PADDR      (paddr),
    .PWDATA     (pwdata),
    .PRDATA     (prdata),
    .PREADY     (pready),
    .PSLVERR    (pslverr),
    .cfg_en     (cfg_en),
    .cfg_cpol   (cfg_cpol),
    .cfg_cpha   (cfg_cpha),
    .cfg_lsbf   (cfg_lsbf),
    .cfg_clkdiv (cfg_clkdiv),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .irq        (irq)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] m_txq[$];
  logic [DW-1:0] m_rxq[$];
  logic [5:0]    m_ctrl   = '0;
  logic [DW-1:0] m_clkdiv = 8'd2;
  bit            m_ovf    = 1'b0;
  bit            m_irq    = 1'b0;

  function automatic bit m_err();
    if (!(psel && penable)) return 1'b0;
    if (int'(paddr) >= 6) return 1'b1;
    if (pwrite && int'(paddr) == 3 && m_txq.size() == DEPTH) return 1'b1;
    if (!pwrite && int'(paddr) == 4 && m_rxq.size() == 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] m_prdata();
    int st;
    if (!(psel && penable) || pwrite || m_err()) return '0;
    case (int'(paddr))
      0: return DW'(m_ctrl);
      1: return m_clkdiv;
      2: begin
        st = (int'(m_ovf) << 4) + ((m_rxq.size() == 0) ? 8 : 0) + ((m_rxq.size() == DEPTH) ? 4 : 0)
           + ((m_txq.size() == 0) ? 2 : 0) + ((m_txq.size() == DEPTH) ? 1 : 0);
        return DW'(st);
      end
      4: return m_rxq[0];
      5: return DW'(m_rxq.size() * 8 + m_txq.size());
      default: return '0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_txq.delete();
      m_rxq.delete();
      m_ctrl   = '0;
      m_clkdiv = 8'd2;
      m_ovf    = 1'b0;
      m_irq    = 1'b0;
    end else begin
      bit acc, e, good_wr, rpop, ovset;
      int txn, rxn;
      acc     = psel && penable;
      e       = m_err();
      good_wr = acc && pwrite && !e;
      txn     = m_txq.size();
      rxn     = m_rxq.size();
      m_irq   = (m_ctrl[4] && txn == 0) || (m_ctrl[5] && rxn != 0) || m_ovf;
      if (txn > 0 && tx_ready) void'(m_txq.pop_front());
      if (good_wr && int'(paddr) == 3) m_txq.push_back(pwdata);
      rpop = acc && !pwrite && !e && int'(paddr) == 4;
      if (rpop) void'(m_rxq.pop_front());
      ovset = 1'b0;
      if (rx_valid) begin
        if (rxn < DEPTH || rpop) m_rxq.push_back(rx_data);
        else ovset = 1'b1;
      end
      if (ovset) m_ovf = 1'b1;
      else if (good_wr && int'(paddr) == 2 && pwdata[4]) m_ovf = 1'b0;
      if (good_wr && int'(paddr) == 0) m_ctrl = pwdata[5:0];
      if (good_wr && int'(paddr) == 1) m_clkdiv = pwdata;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("pready", pready, 1);
    check("tx_valid", tx_valid, m_txq.size() != 0);
    if (m_txq.size() != 0) check("tx_data", tx_data, m_txq[0]);
    check("cfg_bits", {cfg_lsbf, cfg_cpha, cfg_cpol, cfg_en}, m_ctrl[3:0]);
    check("cfg_clkdiv", cfg_clkdiv, m_clkdiv);
    check("irq", irq, m_irq);
    check("pslverr", pslverr, m_err());
    check("prdata", prdata, m_prdata());
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apb(input bit wr, input int addr, input int wdata,
                     output logic [DW-1:0] rd, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = AW'(addr); pwdata = DW'(wdata);
    tick();
    penable = 1'b1;
    @(negedge clk);
    rd  = prdata;
    err = pslverr;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic rd_expect(input string name, input int addr, input int exp_data, input bit exp_err);
    logic [DW-1:0] rd;
    logic          err;
    apb(1'b0, addr, 0, rd, err);
    check({name, " data"}, rd, exp_data);
    check({name, " err"}, err, exp_err);
  endtask

  task automatic wr_expect(input string name, input int addr, input int data, input bit exp_err);
    logic [DW-1:0] rd;
    logic          err;
    apb(1'b1, addr, data, rd, err);
    check({name, " err"}, err, exp_err);
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic          err;
    psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    tx_ready = 0; rx_valid = 0; rx_data = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Reset values
    rd_expect("rst ctrl", 0, 'h00, 0);
    rd_expect("rst clkdiv", 1, 'h02, 0);
    rd_expect("rst status", 2, 'h0A, 0);
    rd_expect("rst count", 5, 'h00, 0);
    check("rst irq", irq, 0);

    // TX fill, overfill, drain
    for (int i = 0; i < 5; i++) wr_expect("tx push", 3, 'h11 + i, 0);
    rd_expect("tx count", 5, 'h05, 0);
    rd_expect("tx status", 2, 'h09, 0);
    wr_expect("tx overfill", 3, 'h16, 1);
    rd_expect("tx count after overfill", 5, 'h05, 0);
    tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("tx drain valid", tx_valid, 1);
      check("tx drain data", tx_data, 'h11 + i);
      tick();
    end
    @(negedge clk);
    check("tx drained", tx_valid, 0);
    tick();
    tx_ready = 1'b0;

    // RX overflow, drain, underflow, W1C
    for (int i = 0; i < 6; i++) begin
      rx_valid = 1'b1; rx_data = DW'('hA0 + i);
      tick();
    end
    rx_valid = 1'b0;
    rd_expect("ovf status", 2, 'h16, 0);
    check("ovf irq", irq, 1);
    for (int i = 0; i < 5; i++) rd_expect("rx pop", 4, 'hA0 + i, 0);
    rd_expect("rx underflow", 4, 'h00, 1);
    wr_expect("ovf w1c", 2, 'h10, 0);
    rd_expect("ovf cleared", 2, 'h0A, 0);
    check("irq cleared", irq, 0);

    // RX full with simultaneous push and pop, across the pointer wrap
    for (int i = 0; i < 5; i++) begin
      rx_valid = 1'b1; rx_data = DW'('hB0 + i);
      tick();
    end
    rx_valid = 1'b0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = AW'(4);
    tick();
    penable = 1'b1; rx_valid = 1'b1; rx_data = 8'hB5;
    @(negedge clk);
    rd = prdata; err = pslverr;
    tick();
    psel = 1'b0; penable = 1'b0; rx_valid = 1'b0;
    check("full pop+push data", rd, 'hB0);
    check("full pop+push err", err, 0);
    rd_expect("full pop+push count", 5, 'h28, 0);
    rd_expect("full pop+push status", 2, 'h06, 0);
    for (int i = 0; i < 5; i++) rd_expect("wrap order", 4, 'hB1 + i, 0);

    // Decode errors and read-only behaviour
    rd_expect("bad rd 7", 7, 'h00, 1);
    wr_expect("bad wr 7", 7, 'hFF, 1);
    rd_expect("bad rd 6", 6, 'h00, 1);
    rd_expect("ctrl after bad wr", 0, 'h00, 0);
    wr_expect("ro wr count", 5, 'hFF, 0);
    rd_expect("count after ro wr", 5, 'h00, 0);
    rd_expect("txdata read", 3, 'h00, 0);
    wr_expect("ctrl all", 0, 'h3F, 0);
    check("cfg all ones", {cfg_lsbf, cfg_cpha, cfg_cpol, cfg_en}, 'hF);
    rd_expect("ctrl readback", 0, 'h3F, 0);
    check("txe irq", irq, 1);
    wr_expect("clkdiv wr", 1, 'h5A, 0);
    rd_expect("clkdiv readback", 1, 'h5A, 0);

    // Asynchronous reset with TX entries pending
    wr_expect("ctrl off", 0, 'h00, 0);
    for (int i = 0; i < 3; i++) wr_expect("pre-rst push", 3, 'hC0 + i, 0);
    check("pre-rst tx_valid", tx_valid, 1);
    #3 rst_n = 1'b0;
    #1;
    check("async tx_valid", tx_valid, 0);
    check("async cfg_clkdiv", cfg_clkdiv, 'h02);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    rd_expect("post-rst count", 5, 'h00, 0);
    rd_expect("post-rst ctrl", 0, 'h00, 0);
    rd_expect("post-rst clkdiv", 1, 'h02, 0);
    rd_expect("post-rst status", 2, 'h0A, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
